seq_detector_param: RTL and testbench

- Parametrised serial pattern detector; successor to the fixed 1101 Moore detector.
- Pattern width, reset pattern and counter width are parameters. The pattern can be loaded at run time.
- Overlapping vs non-overlapping detection is selected at run time. A saturating match counter is provided.
- Sits on a serial bit stream behind a sampled-data strobe; feeds status/interrupt logic.

---
 rtl/seq_detector_param.sv | 162 ++++++++++++++++
 tb/tb_seq_detector_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial pattern detector (Moore output).
// Detects a run-time loadable PAT_W-bit pattern (MSB oldest) on a strobed
// serial stream, with run-time overlap selection and a saturating match
// counter carrying a sticky saturation flag.
// Optional feature: define SEQ_DETECTOR_MASK_EN to add a per-bit compare mask
// (mask_in port, mask register loaded with the pattern; mask bit 0 = don't-care).
module seq_detector_param #(
  parameter int               PAT_W     = 4,
  parameter logic [PAT_W-1:0] RESET_PAT = 4'b1101,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i,
  input  logic             valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_in,
`ifdef SEQ_DETECTOR_MASK_EN
  input  logic [PAT_W-1:0] mask_in,
`endif
  input  logic             overlap_en,
  input  logic             clear,
  output logic             o,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    MATCH = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [PAT_W-1:0]   history, history_nxt, history_shift;
  logic [FILL_W-1:0]  fill, fill_nxt, fill_inc;
  logic [PAT_W-1:0]   pattern, pattern_nxt;
  logic               accept;
  logic               hit;
  logic [CNT_W-1:0]   count_nxt;
  logic               sat_nxt;

`ifdef SEQ_DETECTOR_MASK_EN
  logic [PAT_W-1:0]   mask, mask_nxt;

  // Masked compare: only bits with mask=1 take part.
  function automatic logic pat_equal(input logic [PAT_W-1:0] h,
                                     input logic [PAT_W-1:0] p,
                                     input logic [PAT_W-1:0] m);
    return ((h ^ p) & m) == '0;
  endfunction
`else
  // Exact compare on all pattern bits.
  function automatic logic pat_equal(input logic [PAT_W-1:0] h,
                                     input logic [PAT_W-1:0] p);
    return h == p;
  endfunction
`endif

  // A bit is consumed only when strobed and not pre-empted by a pattern load.
  assign accept        = valid & ~load;
  assign history_shift = {history[PAT_W-2:0], i};
  assign fill_inc      = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);

`ifdef SEQ_DETECTOR_MASK_EN
  assign hit = (fill_inc == FILL_FULL) && pat_equal(history_shift, pattern, mask);
`else
  assign hit = (fill_inc == FILL_FULL) && pat_equal(history_shift, pattern);
`endif

  // Moore output: decoded from the registered state only.
  assign o = (state == MATCH);

  // Next-state: load restarts detection, otherwise advance on accepted bits.
  always_comb begin
    state_nxt   = state;
    history_nxt = history;
    fill_nxt    = fill;
    pattern_nxt = pattern;
`ifdef SEQ_DETECTOR_MASK_EN
    mask_nxt    = mask;
`endif
    if (load) begin
      pattern_nxt = pattern_in;
`ifdef SEQ_DETECTOR_MASK_EN
      mask_nxt    = mask_in;
`endif
      history_nxt = '0;
      fill_nxt    = '0;
      state_nxt   = FILL;
    end else if (accept) begin
      if (hit) begin
        state_nxt = MATCH;
        if (overlap_en) begin
          // Keep the window so the very next bit may complete another match.
          history_nxt = history_shift;
          fill_nxt    = FILL_FULL;
        end else begin
          // Non-overlapping: the next match needs PAT_W fresh bits.
          history_nxt = '0;
          fill_nxt    = '0;
        end
      end else begin
        history_nxt = history_shift;
        fill_nxt    = fill_inc;
        state_nxt   = (fill_inc == FILL_FULL) ? ARMED : FILL;
      end
    end
  end

  // Detection state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= FILL;
      history <= '0;
      fill    <= '0;
      pattern <= RESET_PAT;
`ifdef SEQ_DETECTOR_MASK_EN
      mask    <= '1;
`endif
    end else begin
      state   <= state_nxt;
      history <= history_nxt;
      fill    <= fill_nxt;
      pattern <= pattern_nxt;
`ifdef SEQ_DETECTOR_MASK_EN
      mask    <= mask_nxt;
`endif
    end
  end

  // Counter next value: clear wins over a coincident match; holds at all-ones.
  always_comb begin
    count_nxt = match_count;
    sat_nxt   = count_sat;
    if (clear) begin
      count_nxt = '0;
      sat_nxt   = 1'b0;
    end else if (accept && hit && (match_count != CNT_MAX)) begin
      count_nxt = match_count + CNT_W'(1);
      if (count_nxt == CNT_MAX) begin
        sat_nxt = 1'b1;
      end
    end
  end

  // Match counter and sticky saturation flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      match_count <= count_nxt;
      count_sat   <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed and randomized checks of seq_detector_param
// against a queue-based reference model. Two instances share stimulus: one with
// the default 8-bit counter, one with a 2-bit counter to exercise saturation.
module tb_seq_detector_param;

  localparam int PAT_W = 4;

  logic             clk;
  logic             n_rst;
  logic             i;
  logic             valid;
  logic             load;
  logic [PAT_W-1:0] pattern_in;
  logic             overlap_en;
  logic             clear;
  logic             o8, o2;
  logic [7:0]       cnt8;
  logic [1:0]       cnt2;
  logic             sat8, sat2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit               hq[$];
  logic [PAT_W-1:0] m_pat;
  logic             m_o;
  int               m_cnt8, m_cnt2;
  logic             m_sat8, m_sat2;

  seq_detector_param #(.PAT_W(PAT_W), .RESET_PAT(4'b1101), .CNT_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .i(i), .valid(valid), .load(load),
    .pattern_in(pattern_in), .overlap_en(overlap_en), .clear(clear),
    .o(o8), .match_count(cnt8), .count_sat(sat8)
  );

  seq_detector_param #(.PAT_W(PAT_W), .RESET_PAT(4'b1101), .CNT_W(2)) dut_s (
    .clk(clk), .n_rst(n_rst), .i(i), .valid(valid), .load(load),
    .pattern_in(pattern_in), .overlap_en(overlap_en), .clear(clear),
    .o(o2), .match_count(cnt2), .count_sat(sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PAT_W-1:0] q2val();
    logic [PAT_W-1:0] v = '0;
    foreach (hq[k]) v = {v[PAT_W-2:0], hq[k]};
    return v;
  endfunction

  task automatic model_reset();
    hq.delete();
    m_pat  = 4'b1101;
    m_o    = 1'b0;
    m_cnt8 = 0;
    m_cnt2 = 0;
    m_sat8 = 1'b0;
    m_sat2 = 1'b0;
  endtask

  // One clock edge of the reference: last PAT_W accepted bits since restart vs pattern.
  task automatic model_edge();
    bit match = 0;
    if (load) begin
      m_pat = pattern_in;
      hq.delete();
      m_o = 1'b0;
    end else if (valid) begin
      hq.push_back(i);
      if (hq.size() > PAT_W) void'(hq.pop_front());
      if (hq.size() == PAT_W && q2val() == m_pat) begin
        match = 1;
        m_o = 1'b1;
        if (!overlap_en) hq.delete();
      end else begin
        m_o = 1'b0;
      end
    end
    if (clear) begin
      m_cnt8 = 0; m_sat8 = 1'b0;
      m_cnt2 = 0; m_sat2 = 1'b0;
    end else if (match) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt8 == 255) m_sat8 = 1'b1;
      if (m_cnt2 < 3) m_cnt2++;
      if (m_cnt2 == 3) m_sat2 = 1'b1;
    end
  endtask

  // Apply inputs at the negedge, clock once, compare at the following negedge.
  task automatic cycle(input logic vi, input logic vv, input logic vl,
                       input logic [PAT_W-1:0] vp, input logic vov, input logic vc);
    i = vi; valid = vv; load = vl; pattern_in = vp; overlap_en = vov; clear = vc;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("o", o8, m_o);
    chk("o_small", o2, m_o);
    chk("count", cnt8, m_cnt8);
    chk("sat", sat8, m_sat8);
    chk("count_small", cnt2, m_cnt2);
    chk("sat_small", sat2, m_sat2);
  endtask

  task automatic bit_in(input logic b, input logic ov);
    cycle(b, 1'b1, 1'b0, 4'b0000, ov, 1'b0);
  endtask

  task automatic idle(input logic ov);
    cycle(1'b0, 1'b0, 1'b0, 4'b0000, ov, 1'b0);
  endtask

  task automatic do_load(input logic [PAT_W-1:0] p, input logic ov);
    cycle(1'b0, 1'b0, 1'b1, p, ov, 1'b1);
  endtask

  initial begin
    logic [6:0] stream;
    logic [6:0] exp_ov;
    logic [6:0] exp_nov;
    logic [3:0] s4;
    logic       ov;

    stream  = 7'b1101101;
    exp_ov  = 7'b0001001;
    exp_nov = 7'b0001000;

    // Power-on reset
    n_rst = 1'b0; i = 0; valid = 0; load = 0; pattern_in = '0; overlap_en = 1; clear = 0;
    model_reset();
    #1;
    chk("rst_o", o8, 0);
    chk("rst_count", cnt8, 0);
    chk("rst_sat", sat8, 0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // Default pattern, overlapping
    do_load(4'b1101, 1'b1);
    for (int k = 6; k >= 0; k--) begin
      bit_in(stream[k], 1'b1);
      chk("ovl_seq", o8, exp_ov[k]);
    end
    chk("ovl_count", cnt8, 2);

    // Same stream, non-overlapping
    do_load(4'b1101, 1'b0);
    for (int k = 6; k >= 0; k--) begin
      bit_in(stream[k], 1'b0);
      chk("novl_seq", o8, exp_nov[k]);
    end
    chk("novl_count", cnt8, 1);

    // Valid gaps: o holds through idle cycles until the next accepted bit
    do_load(4'b1101, 1'b1);
    bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b1);
    repeat (3) idle(1'b1);
    bit_in(1'b0, 1'b1);
    chk("gap_pre", o8, 0);
    bit_in(1'b1, 1'b1);
    chk("gap_hit", o8, 1);
    repeat (2) begin
      idle(1'b1);
      chk("gap_hold", o8, 1);
    end
    bit_in(1'b0, 1'b1);
    chk("gap_drop", o8, 0);

    // Mid-stream load of 0110 restarts detection
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    do_load(4'b0110, 1'b0);
    chk("load_o", o8, 0);
    s4 = 4'b0110;
    for (int k = 3; k >= 0; k--) bit_in(s4[k], 1'b0);
    chk("load_hit", o8, 1);
    s4 = 4'b1101;
    for (int k = 3; k >= 0; k--) begin
      bit_in(s4[k], 1'b0);
      chk("load_nohit", o8, 0);
    end

    // Saturation of the 2-bit counter, then clear coinciding with a match
    do_load(4'b1111, 1'b1);
    repeat (7) bit_in(1'b1, 1'b1);
    chk("sat_count2", cnt2, 3);
    chk("sat_flag2", sat2, 1);
    chk("sat_count8", cnt8, 4);
    chk("sat_flag8", sat8, 0);
    cycle(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
    chk("clr_o", o8, 1);
    chk("clr_count2", cnt2, 0);
    chk("clr_flag2", sat2, 0);
    chk("clr_count8", cnt8, 0);

    // Randomized traffic
    ov = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic vl;
      logic [PAT_W-1:0] vp;
      if ($urandom_range(0, 15) == 0) ov = ~ov;
      vl = ($urandom_range(0, 59) == 0);
      vp = ($urandom_range(0, 1) == 0) ? 4'b1111 : PAT_W'($urandom);
      cycle(1'($urandom), ($urandom_range(0, 3) != 0), vl, vp, ov,
            ($urandom_range(0, 79) == 0));
    end

    // Asynchronous reset asserted mid-cycle
    do_load(4'b1111, 1'b1);
    repeat (5) bit_in(1'b1, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_o", o8, 0);
    chk("arst_count", cnt8, 0);
    chk("arst_sat2", sat2, 0);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    chk("arst_rel_o", o8, 0);
    chk("arst_rel_count", cnt8, 0);
    // Reset pattern 1101 is back in effect
    s4 = 4'b1101;
    for (int k = 3; k >= 0; k--) bit_in(s4[k], 1'b1);
    chk("arst_pat", o8, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
